instr_feeder: RTL and testbench
===============================

# instr_feeder

Instruction sequencer on the issuing side of the `proc` Run/Done interface. A host loads a short program of 9-bit words into an internal buffer, then pulses `Start`. The block then issues each instruction to the processor: opcode word with `Run`, the immediate word for `MVI`, then a wait for `Done` before the next instruction. It sits between a host/test harness and `proc`, driving `proc.DIN` and `proc.Run` and consuming `proc.Done`.

## Interface
Parameters:
- `AW`, 4: program buffer address width; depth is 2^AW words.
- `TIMEOUT`, 8: maximum wait cycles for `Done`. Used only with `FEEDER_TIMEOUT_EN`.

Ports:
- `Clock`: in, 1. Single clock, rising edge.
- `Resetn`: in, 1. Asynchronous, active-low reset.
- `wr_en`: in, 1. Program buffer write strobe.
- `wr_addr`: in, AW. Write address.
- `wr_data`: in, 9. Word to store.
- `Start`: in, 1. Begin issuing `mem[0 .. Length-1]`.
- `Length`: in, AW+1. Program length in words, sampled at `Start`.
- `DIN`: out, 9. Registered. Drives `proc.DIN`.
- `Run`: out, 1. Registered. Drives `proc.Run`.
- `Done`: in, 1. From `proc.Done`.
- `Busy`: out, 1. High from accepted `Start` until completion or abort.
- `Finished`: out, 1. Level. Program completed; cleared by the next accepted `Start`.
- `Error`: out, 1. Timeout abort. Constant 0 without the macro.
- `Pc`: out, AW+1. Index of the current instruction word.

## Operation
- Opcode is `word[8:6]`: `000` MV, `001` MVI, `010` ADD, `011` SUB. Only `001` consumes an extra word.
- Buffer:
  - 2^AW x 9 register array with combinational read. Not cleared by reset.
  - A write lands at the clock edge when `wr_en`=1 and `Busy`=0. Writes while `Busy` are ignored.
- States:
  - IDLE: `Run`=0, `DIN`=0.
    - `Start`=1 latches `Length`, sets `Pc`=0, sets `Busy`=1, clears `Finished` and `Error`.
    - Goes to ISSUE, or to END if `Length`=0.
  - ISSUE (exactly 1 cycle): `Run`=1, `DIN`=`mem[Pc]`. Goes to WAIT.
  - WAIT: `Run`=0.
    - For MVI, `DIN`=`mem[Pc+1]`, or 0 if `Pc+1`=`Length`. Otherwise `DIN`=0. `DIN` is held for the whole of WAIT.
    - On `Done`=1 at an edge, `Pc` += 2 for MVI, else += 1, saturating at `Length`.
    - Then goes to ISSUE if the new `Pc` < `Length`, else to END.
  - END (1 cycle): `Busy`=0, `Finished`=1. Goes to IDLE.
- `Start` is ignored unless in IDLE.
- `Done` is ignored in IDLE, ISSUE and END.
- Reset (any time, including mid-program): IDLE, `Run`=0, `DIN`=0, `Busy`=0, `Finished`=0, `Error`=0, `Pc`=0. The first instruction after reset re-issues from word 0 only on a new `Start`.

## Timing
- Edge after `Start`: `Run`=1 and `DIN`=instruction (ISSUE). The processor latches IR on the following edge.
- Cycle after ISSUE: `DIN` carries the immediate. This is the processor's T1 bus slot for MVI.
- `Done` is accepted from the first WAIT cycle onward. MV/MVI `Done` arrives in that first WAIT cycle.
- Minimum per instruction: 2 cycles (ISSUE + one WAIT cycle), so back-to-back issue gives `Run` at most every 2nd cycle.
- `Finished` rises 1 cycle after the final accepted `Done`.
- `Busy` falls on the same edge that `Finished` rises.

## Configuration
- `FEEDER_TIMEOUT_EN` defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without `Done`.
  - When the counter reaches `TIMEOUT`: `Error`=1, `Busy`=0, `Finished`=0, `Run`=0, `DIN`=0, go to IDLE.
  - `Pc` keeps the index of the stalled instruction.
  - If `Done` and the timeout occur in the same cycle, `Done` wins.
- `FEEDER_TIMEOUT_EN` undefined: no counter; WAIT lasts indefinitely; `Error` is tied to 0.

## Test plan
- Program MVI R0,5 (`001000000`, `000000101`); `Start`, `Length`=2; `Done` 1 cycle after ISSUE.
  - Expect `Run`=1 with `DIN`=`001000000`, then `DIN`=5 held, then `Finished`=1 with `Pc`=2.
- MVI R0,5; MV R1,R0 (`000001000`); ADD R0,R1 (`010000001`); `Length`=4; `Done` after 1, 1 and 3 WAIT cycles.
  - Expect 3 `Run` pulses, with `DIN` values `001000000`, `000001000`, `010000001`.
  - Expect `Pc` sequence 0, 2, 3, 4.
- `Length`=0 -> no `Run`; `Busy` high for 1 cycle; `Finished`=1.
- `Resetn` asserted during WAIT of the 2nd instruction.
  - Expect all outputs 0 at once and state IDLE.
  - After a new `Start`, issue resumes at word 0 with buffer contents intact.
- `wr_en` pulsed while `Busy` -> buffer word unchanged. `Start` pulsed while `Busy` -> ignored; `Pc` keeps advancing as before.
- With `FEEDER_TIMEOUT_EN` and `TIMEOUT`=8, `Done` never asserted.
  - Expect `Error`=1 after 8 WAIT cycles, with `Pc`=0, `Busy`=0, `Finished`=0.
  - A following `Start` clears `Error`.

Source files
------------

// File: rtl/instr_feeder.sv
// Instruction sequencer feeding a proc Run/Done interface from a small program buffer.
// Optional Done timeout abort is enabled by defining FEEDER_TIMEOUT_EN.
module instr_feeder #(
   parameter int unsigned AW      = 4,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [8:0]    wr_data,
   input  logic          Start,
   input  logic [AW:0]   Length,
   output logic [8:0]    DIN,
   output logic          Run,
   input  logic          Done,
   output logic          Busy,
   output logic          Finished,
   output logic          Error,
   output logic [AW:0]   Pc
);

   localparam int unsigned Depth = 2 ** AW;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StEnd} state_e;

   state_e        state_q, state_d;
   logic [AW:0]   pc_q, pc_d;
   logic [AW:0]   len_q, len_d;
   logic [8:0]    din_q, din_d;
   logic          run_q, run_d;
   logic          busy_q, busy_d;
   logic          fin_q, fin_d;
   logic [8:0]    mem_q [Depth];

   logic [8:0]    cur_word;
   logic          cur_mvi;
   logic [AW+1:0] pc_inc;
   logic [AW:0]   pc_adv;
   logic [8:0]    nxt_word;
   logic [AW:0]   nxt_p1;

`ifdef FEEDER_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   logic [CntW-1:0] wcnt_q, wcnt_d;
   logic            err_q, err_d;
`endif

   always_ff @(posedge Clock) begin
      if (wr_en && !busy_q) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Advance past the immediate word for MVI, never beyond the program end.
   assign cur_word = mem_q[pc_q[AW-1:0]];
   assign cur_mvi  = (cur_word[8:6] == 3'b001);
   assign pc_inc   = {1'b0, pc_q} + (cur_mvi ? (AW+2)'(2) : (AW+2)'(1));
   assign pc_adv   = (pc_inc > {1'b0, len_q}) ? len_q : pc_inc[AW:0];

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      len_d    = len_q;
      busy_d   = busy_q;
      fin_d    = fin_q;
      run_d    = 1'b0;
      din_d    = 9'd0;
      nxt_word = 9'd0;
      nxt_p1   = '0;
`ifdef FEEDER_TIMEOUT_EN
      wcnt_d   = wcnt_q;
      err_d    = err_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (Start) begin
               len_d   = Length;
               pc_d    = '0;
               busy_d  = 1'b1;
               fin_d   = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = (Length == '0) ? StEnd : StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
`ifdef FEEDER_TIMEOUT_EN
            wcnt_d  = '0;
`endif
         end
         StWait: begin
            if (Done) begin
               pc_d    = pc_adv;
               state_d = (pc_adv < len_q) ? StIssue : StEnd;
            end
`ifdef FEEDER_TIMEOUT_EN
            else if (wcnt_q == CntW'(TIMEOUT - 1)) begin
               busy_d  = 1'b0;
               fin_d   = 1'b0;
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
`endif
         end
         StEnd: begin
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered, so decode them from the state being entered.
      nxt_word = mem_q[pc_d[AW-1:0]];
      nxt_p1   = pc_d + 1'b1;
      if (state_d == StIssue) begin
         run_d = 1'b1;
         din_d = nxt_word;
      end else if (state_d == StWait) begin
         if ((nxt_word[8:6] == 3'b001) && (nxt_p1 != len_d)) begin
            din_d = mem_q[nxt_p1[AW-1:0]];
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= StIdle;
         pc_q    <= '0;
         len_q   <= '0;
         din_q   <= 9'd0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
         wcnt_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         din_q   <= din_d;
         run_q   <= run_d;
         busy_q  <= busy_d;
         fin_q   <= fin_d;
`ifdef FEEDER_TIMEOUT_EN
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign DIN      = din_q;
   assign Run      = run_q;
   assign Busy     = busy_q;
   assign Finished = fin_q;
   assign Pc       = pc_q;
`ifdef FEEDER_TIMEOUT_EN
   assign Error    = err_q;
`else
   assign Error    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: cycle vector table plus reset, busy-guard and timeout sequences.
module tb_instr_feeder;

   localparam int unsigned AW = 4;

   logic          Clock = 1'b0;
   logic          Resetn = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [8:0]    wr_data = '0;
   logic          Start = 1'b0;
   logic [AW:0]   Length = '0;
   logic [8:0]    DIN;
   logic          Run;
   logic          Done = 1'b0;
   logic          Busy;
   logic          Finished;
   logic          Error;
   logic [AW:0]   Pc;

   int n_checks = 0;
   int n_fail   = 0;

   instr_feeder #(.AW(AW), .TIMEOUT(8)) dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .Start    (Start),
      .Length   (Length),
      .DIN      (DIN),
      .Run      (Run),
      .Done     (Done),
      .Busy     (Busy),
      .Finished (Finished),
      .Error    (Error),
      .Pc       (Pc)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic        start;
      logic [4:0]  len;
      logic        done;
      logic        run;
      logic [8:0]  din;
      logic        busy;
      logic        fin;
      logic        err;
      logic [4:0]  pc;
   } vec_t;

   // {Run, DIN, Busy, Finished, Error, Pc}
   function automatic logic [17:0] pack(logic r, logic [8:0] d, logic b, logic f, logic e,
                                        logic [4:0] p);
      return {r, d, b, f, e, p};
   endfunction

   task automatic check(string name, logic [17:0] exp);
      logic [17:0] act;
      act = pack(Run, DIN, Busy, Finished, Error, Pc);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got run=%0b din=%h busy=%0b fin=%0b err=%0b pc=%0d, want run=%0b din=%h busy=%0b fin=%0b err=%0b pc=%0d",
                  name, act[17], act[16:8], act[7], act[6], act[5], act[4:0],
                  exp[17], exp[16:8], exp[7], exp[6], exp[5], exp[4:0]);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [8:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic run_to_finish(string name, input logic [4:0] exp_pc);
      int cyc;
      cyc = 0;
      Done = 1'b1;
      while (!Finished && cyc < 60) begin
         step();
         cyc++;
      end
      Done = 1'b0;
      check(name, pack(1'b0, 9'd0, 1'b0, 1'b1, 1'b0, exp_pc));
   endtask

   vec_t vecs [15];

   initial begin
      // Test 1: MVI R0,5 with Length=2
      vecs[0]  = '{1, 2, 0, 1, 9'h040, 1, 0, 0, 0};
      vecs[1]  = '{0, 0, 0, 0, 9'h005, 1, 0, 0, 0};
      vecs[2]  = '{0, 0, 1, 0, 9'h000, 1, 0, 0, 2};
      vecs[3]  = '{0, 0, 0, 0, 9'h000, 0, 1, 0, 2};
      // Test 2: MVI; MV; ADD with Length=4, Done after 1, 1, 3 WAIT cycles
      vecs[4]  = '{1, 4, 0, 1, 9'h040, 1, 0, 0, 0};
      vecs[5]  = '{0, 0, 0, 0, 9'h005, 1, 0, 0, 0};
      vecs[6]  = '{0, 0, 1, 1, 9'h008, 1, 0, 0, 2};
      vecs[7]  = '{0, 0, 0, 0, 9'h000, 1, 0, 0, 2};
      vecs[8]  = '{0, 0, 1, 1, 9'h081, 1, 0, 0, 3};
      vecs[9]  = '{0, 0, 0, 0, 9'h000, 1, 0, 0, 3};
      vecs[10] = '{0, 0, 0, 0, 9'h000, 1, 0, 0, 3};
      vecs[11] = '{0, 0, 1, 0, 9'h000, 1, 0, 0, 4};
      vecs[12] = '{0, 0, 0, 0, 9'h000, 0, 1, 0, 4};
      // Length=0: one Busy cycle, no Run
      vecs[13] = '{1, 0, 0, 0, 9'h000, 1, 0, 0, 0};
      vecs[14] = '{0, 0, 0, 0, 9'h000, 0, 1, 0, 0};

      #12;
      check("reset_state", pack(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 5'd0));
      Resetn = 1'b1;
      step();

      write_word(4'd0, 9'b001000000);
      write_word(4'd1, 9'b000000101);
      write_word(4'd2, 9'b000001000);
      write_word(4'd3, 9'b010000001);

      for (int i = 0; i < 15; i++) begin
         Start  = vecs[i].start;
         Length = vecs[i].len;
         Done   = vecs[i].done;
         step();
         Start = 1'b0;
         Done  = 1'b0;
         check($sformatf("vec%0d", i), pack(vecs[i].run, vecs[i].din, vecs[i].busy,
                                            vecs[i].fin, vecs[i].err, vecs[i].pc));
      end

      // Reset during WAIT of the second instruction
      Start = 1'b1; Length = 5'd4; step(); Start = 1'b0;
      step();
      Done = 1'b1; step(); Done = 1'b0;
      step();
      check("pre_reset_wait2", pack(1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 5'd2));
      #2 Resetn = 1'b0;
      #1 check("async_reset", pack(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 5'd0));
      #2 Resetn = 1'b1;
      step();
      step();
      check("idle_after_reset", pack(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 5'd0));
      Start = 1'b1; Length = 5'd4; step(); Start = 1'b0;
      check("reissue_word0", pack(1'b1, 9'h040, 1'b1, 1'b0, 1'b0, 5'd0));
      run_to_finish("reset_rerun_finish", 5'd4);

      // Write and Start while Busy are ignored
      Start = 1'b1; Length = 5'd4; step(); Start = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 9'h1ff;
      Start = 1'b1; Length = 5'd1;
      step();
      wr_en = 1'b0; Start = 1'b0;
      check("busy_guard_wait", pack(1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 5'd0));
      Done = 1'b1; step(); Done = 1'b0;
      check("start_ignored_pc", pack(1'b1, 9'h008, 1'b1, 1'b0, 1'b0, 5'd2));
      run_to_finish("busy_guard_finish", 5'd4);
      Start = 1'b1; Length = 5'd2; step(); Start = 1'b0;
      step();
      check("buffer_intact", pack(1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 5'd0));
      run_to_finish("buffer_check_finish", 5'd2);

`ifdef FEEDER_TIMEOUT_EN
      Start = 1'b1; Length = 5'd2; step(); Start = 1'b0;
      step();
      repeat (7) step();
      check("timeout_not_yet", pack(1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 5'd0));
      step();
      check("timeout_abort", pack(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 5'd0));
      Start = 1'b1; Length = 5'd2; step(); Start = 1'b0;
      check("start_clears_error", pack(1'b1, 9'h040, 1'b1, 1'b0, 1'b0, 5'd0));
      run_to_finish("after_timeout_finish", 5'd2);
`else
      Start = 1'b1; Length = 5'd2; step(); Start = 1'b0;
      repeat (20) step();
      check("wait_indefinitely", pack(1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 5'd0));
      run_to_finish("no_timeout_finish", 5'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
